sobel_grad: RTL and testbench
=============================

# sobel_grad

Streaming 3x3 Sobel gradient generator: consumes a raster-order grayscale pixel stream and produces signed horizontal/vertical gradient pairs on a valid/ready stream. It is the upstream producer of the gradient-magnitude stage. Its gx/gy outputs match that stage's signed `Width`-bit inputs, and it honours the same ready/valid semantics. It sits between the camera pixel path and the magnitude/threshold pipeline.

## Interface
- `PixelWidth`, 8, unsigned pixel bits.
- `Width`, 14, signed gradient output bits; must be >= PixelWidth+3.
- `LineWidth`, 640, pixels per line (>= 3).
- `FrameHeight`, 480, lines per frame (>= 3).

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `valid_i`  in  1  pixel valid.
- `pixel_i`  in  PixelWidth  unsigned pixel, raster order.
- `ready_o`  out  1  pixel accepted when `valid_i & ready_o`.
- `valid_o`  out  1  gradient pair valid.
- `gx_o`  out  Width  signed horizontal gradient.
- `gy_o`  out  Width  signed vertical gradient.
- `ready_i`  in  1  downstream ready.

## Operation
- Storage:
  - Two line buffers, LineWidth x PixelWidth each, hold rows r-1 and r-2.
  - A 3x3 window register holds p[row][col], with row 2 and col 2 newest.
  - Line-buffer contents are not reset.
- Counters:
  - `col` counts 0..LineWidth-1 and wraps to 0, incrementing `row`.
  - `row` counts 0..FrameHeight-1 and wraps to 0, which starts a new frame.
- On each accepted pixel:
  - Shift the window left.
  - Load the new column from {line buffer r-2, line buffer r-1, pixel_i}.
  - Write the line buffers at `col`.
  - Advance the counters.
- Window valid: `row >= 2 && col >= 2` (pre-increment position of the accepted pixel). Stale data from the previous line or frame is masked by this gate.
- Arithmetic:
  - gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20).
  - gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02).
  - Compute at PixelWidth+3 bits, then sign-extend to Width.
  - Range is ±4·(2^PixelWidth−1), so overflow is impossible.
- Output is a single register stage:
  - `ready_o = ready_i | ~valid_o`.
  - An accepted pixel with a valid window loads gx_o/gy_o and sets `valid_o`.
  - An accepted pixel without a valid window, or a completed output handshake with no new load, clears `valid_o`.
- While `valid_o & ~ready_i`: outputs are held stable and no input is accepted.
- Ordering is strict raster order of window centres; no drops, no duplicates.

## Timing
- Reset values:
  - `valid_o`=0, `gx_o`=0, `gy_o`=0.
  - `col`=0, `row`=0, window registers 0.
  - `ready_o` is 1 after reset (follows from `valid_o`=0).
- Latency: 1 cycle from accepting the pixel at (r,c) to `valid_o` carrying the gradient centred at (r−1,c−1).
- Throughput: 1 pair per cycle with `ready_i` held high.
- Outputs per frame: (LineWidth−2)·(FrameHeight−2).
- Simultaneous output handshake and new valid load in the same cycle: the register reloads, `valid_o` stays 1, and there is no bubble.
- Line wrap and frame wrap take effect on the same accept edge as the last pixel. The next pixel is (r+1,0) or (0,0).
- Reset mid-frame takes effect immediately:
  - In-flight output is discarded.
  - The next accepted pixel is treated as (0,0).

## Configuration
- `SOBEL_GRAD_BORDER_EN`
  - Defined: every accepted pixel produces an output. Positions with an invalid window emit gx=gy=0 with `valid_o`=1, giving LineWidth·FrameHeight outputs per frame, aligned 1:1 with the input stream.
  - Undefined: border positions produce no output, as described above.

## Test plan
All scenarios use LineWidth=4, FrameHeight=4, PixelWidth=8, Width=14.
- Constant frame of 100, `ready_i`=1 -> exactly 4 outputs, all gx=0, gy=0; `valid_o` low afterwards.
- Horizontal ramp pixel=10·c -> 4 outputs, each gx=80, gy=0.
- Vertical step (rows 0–1 = 0, rows 2–3 = 255) -> outputs gy=1020, gx=0 for all 4. Column-mirrored step (cols 0–1 = 255, cols 2–3 = 0) -> gx=−1020, i.e. 14'h3C04.
- Two back-to-back ramp frames with `ready_i` low for 5 cycles mid-stream:
  - `ready_o` low while stalled.
  - gx/gy stable while stalled.
  - 8 outputs total, in order, all correct.
- Assert `rst_i` after 7 pixels, then send a full constant frame -> `valid_o`=0 immediately, then exactly 4 zero-gradient outputs.
- With `SOBEL_GRAD_BORDER_EN`, horizontal ramp frame -> 16 outputs:
  - Outputs with index row>=2, col>=2 (indices 10, 11, 14, 15) give gx=80.
  - The other 12 are zero.

Source files
------------

// File: rtl/sobel_grad.sv
// sobel_grad -- streaming 3x3 Sobel gradient generator.
//
// Consumes a raster-order unsigned pixel stream and produces signed
// horizontal (gx) and vertical (gy) gradient pairs. Two line buffers hold
// the previous two rows. A 3x3 window slides one column per accepted pixel.
// A single output register stage carries the result on a valid/ready stream.
//
// Ports:
//   clk_i    clock
//   rst_i    asynchronous, active-high reset
//   valid_i  input pixel valid
//   pixel_i  unsigned pixel, raster order
//   ready_o  pixel accepted when valid_i & ready_o
//   valid_o  gradient pair valid
//   gx_o     signed horizontal gradient
//   gy_o     signed vertical gradient
//   ready_i  downstream ready
//
// Optional feature macro: SOBEL_GRAD_BORDER_EN
//   When defined, every accepted pixel produces an output. Positions without
//   a full window emit gx = gy = 0.
//   When undefined, border positions produce no output.
module sobel_grad #(
    parameter int PixelWidth  = 8,
    parameter int Width       = 14,
    parameter int LineWidth   = 640,
    parameter int FrameHeight = 480
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_i,
    input  logic        [PixelWidth-1:0] pixel_i,
    output logic                         ready_o,
    output logic                         valid_o,
    output logic signed [Width-1:0]      gx_o,
    output logic signed [Width-1:0]      gy_o,
    input  logic                         ready_i
);

    localparam int CW    = PixelWidth + 3;
    localparam int COL_W = $clog2(LineWidth);
    localparam int ROW_W = $clog2(FrameHeight);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LineWidth - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FrameHeight - 1);

    // Pixel zero-extended into the signed compute width.
    function automatic logic signed [CW-1:0] ext1(input logic [PixelWidth-1:0] p);
        return $signed({3'b000, p});
    endfunction

    // Twice the pixel, as a shift, in the signed compute width.
    function automatic logic signed [CW-1:0] ext2(input logic [PixelWidth-1:0] p);
        return $signed({2'b00, p, 1'b0});
    endfunction

    // Sign-extend a compute-width result to the output width.
    // The full range is +/-4*(2^PixelWidth-1), so no saturation is needed.
    function automatic logic signed [Width-1:0] sext(input logic signed [CW-1:0] v);
        logic signed [Width-1:0] r;
        r = v;
        return r;
    endfunction

    logic [PixelWidth-1:0] lb1_mem [LineWidth];  // row r-1
    logic [PixelWidth-1:0] lb2_mem [LineWidth];  // row r-2

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic [PixelWidth-1:0] win_p0 [3][3];
    logic [PixelWidth-1:0] win_nxt [3][3];

    logic                   accept;
    logic                   win_ok;
    logic                   vld_p1;
    logic signed [CW-1:0]   gx_c;
    logic signed [CW-1:0]   gy_c;
    logic [PixelWidth-1:0]  lb1_rd;
    logic [PixelWidth-1:0]  lb2_rd;

    assign ready_o = ready_i | ~vld_p1;
    assign valid_o = vld_p1;
    assign accept  = valid_i & ready_o;
    assign lb1_rd  = lb1_mem[col];
    assign lb2_rd  = lb2_mem[col];

    // The gate uses the pre-increment position, which masks stale rows left
    // over from the previous line or frame.
    assign win_ok = (row >= ROW_W'(2)) && (col >= COL_W'(2));

    // ---- stage p0: window shift and gradient arithmetic ----
    // The next window is formed combinationally, so the gradient lands in the
    // output register on the same edge that accepts the pixel.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_nxt[r][0] = win_p0[r][1];
            win_nxt[r][1] = win_p0[r][2];
            win_nxt[r][2] = '0;
        end
        win_nxt[0][2] = lb2_rd;
        win_nxt[1][2] = lb1_rd;
        win_nxt[2][2] = pixel_i;
    end

    always_comb begin
        gx_c = (ext1(win_nxt[0][2]) + ext2(win_nxt[1][2]) + ext1(win_nxt[2][2]))
             - (ext1(win_nxt[0][0]) + ext2(win_nxt[1][0]) + ext1(win_nxt[2][0]));
        gy_c = (ext1(win_nxt[2][0]) + ext2(win_nxt[2][1]) + ext1(win_nxt[2][2]))
             - (ext1(win_nxt[0][0]) + ext2(win_nxt[0][1]) + ext1(win_nxt[0][2]));
    end

    // Line buffer contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb2_mem[col] <= lb1_rd;
            lb1_mem[col] <= pixel_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col <= '0;
            row <= '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_p0[r][c] <= '0;
        end else if (accept) begin
            win_p0 <= win_nxt;
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // ---- stage p1: output register ----
    // Reloading while a pair is being handed off keeps vld_p1 high, so there
    // is no bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1 <= 1'b0;
            gx_o   <= '0;
            gy_o   <= '0;
        end else if (accept) begin
            if (win_ok) begin
                vld_p1 <= 1'b1;
                gx_o   <= sext(gx_c);
                gy_o   <= sext(gy_c);
            end else begin
`ifdef SOBEL_GRAD_BORDER_EN
                vld_p1 <= 1'b1;
                gx_o   <= '0;
                gy_o   <= '0;
`else
                vld_p1 <= 1'b0;
`endif
            end
        end else if (ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_grad.sv
// Directed testbench for sobel_grad with a 4x4 frame and 8-bit pixels.
// Expected gradients are hand-computed per test pattern.
module tb_sobel_grad;

    localparam int PW = 8;
    localparam int W  = 14;
    localparam int LW = 4;
    localparam int FH = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                valid_i;
    logic [PW-1:0]       pixel_i;
    logic                ready_o;
    logic                valid_o;
    logic signed [W-1:0] gx_o;
    logic signed [W-1:0] gy_o;
    logic                ready_i;

    sobel_grad #(
        .PixelWidth (PW),
        .Width      (W),
        .LineWidth  (LW),
        .FrameHeight(FH)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .valid_i(valid_i),
        .pixel_i(pixel_i),
        .ready_o(ready_o),
        .valid_o(valid_o),
        .gx_o   (gx_o),
        .gy_o   (gy_o),
        .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         gx_q[$];
    int         gy_q[$];
    logic [W-1:0] gxraw_q[$];

    // Record every completed output handshake; inputs change only just after
    // the rising edge, so the negedge view equals the next edge's view.
    always @(negedge clk) begin
        if (!rst && valid_o && ready_i) begin
            gx_q.push_back(int'(gx_o));
            gy_q.push_back(int'(gy_o));
            gxraw_q.push_back(gx_o);
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pix(input int kind, input int r, input int c);
        case (kind)
            0:       return PW'(100);
            1:       return PW'(10 * c);
            2:       return (r >= 2) ? PW'(255) : PW'(0);
            3:       return (c < 2) ? PW'(255) : PW'(0);
            default: return PW'(200);
        endcase
    endfunction

    task automatic clear_q();
        gx_q.delete();
        gy_q.delete();
        gxraw_q.delete();
    endtask

    task automatic send(input logic [PW-1:0] p);
        int waited;
        valid_i = 1'b1;
        pixel_i = p;
        waited  = 0;
        @(negedge clk);
        while (!ready_o && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_o) check_val("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic send_frame(input int kind);
        for (int r = 0; r < FH; r++)
            for (int c = 0; c < LW; c++)
                send(pix(kind, r, c));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input int n, input int ex_gx, input int ex_gy);
        check_val({tag, "_count"}, gx_q.size(), n);
        for (int i = 0; i < gx_q.size(); i++) begin
            check_val($sformatf("%s_gx%0d", tag, i), gx_q[i], ex_gx);
            check_val($sformatf("%s_gy%0d", tag, i), gy_q[i], ex_gy);
        end
    endtask

    int held_gx;
    int held_gy;

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        pixel_i = '0;
        idle(2);
        check_val("rst_valid", int'(valid_o), 0);
        check_val("rst_gx", int'(gx_o), 0);
        check_val("rst_gy", int'(gy_o), 0);
        check_val("rst_ready", int'(ready_o), 1);
        rst = 1'b0;
        idle(1);

`ifndef SOBEL_GRAD_BORDER_EN
        // Constant frame: flat image, zero gradients.
        clear_q();
        send_frame(0);
        idle(3);
        check_frame("const", 4, 0, 0);
        check_val("const_valid_after", int'(valid_o), 0);

        // Horizontal ramp 10*c: gx = 4*20 = 80.
        clear_q();
        send_frame(1);
        idle(3);
        check_frame("ramp", 4, 80, 0);

        // Vertical step 0 -> 255: gy = 4*255 = 1020.
        clear_q();
        send_frame(2);
        idle(3);
        check_frame("vstep", 4, 0, 1020);

        // Column-mirrored step: gx = -1020 = 14'h3C04.
        clear_q();
        send_frame(3);
        idle(3);
        check_frame("hstep", 4, -1020, 0);
        if (gxraw_q.size() > 0)
            check_val("hstep_raw", int'(gxraw_q[0]), 32'h3C04);

        // Two back-to-back ramp frames with a 5-cycle downstream stall.
        clear_q();
        for (int i = 0; i < 11; i++) send(pix(1, i / LW, i % LW));
        check_val("stall_pre_valid", int'(valid_o), 1);
        valid_i = 1'b1;
        pixel_i = pix(1, 2, 3);
        ready_i = 1'b0;
        held_gx = int'(gx_o);
        held_gy = int'(gy_o);
        repeat (5) begin
            @(negedge clk);
            check_val("stall_ready", int'(ready_o), 0);
            check_val("stall_valid", int'(valid_o), 1);
            check_val("stall_gx", int'(gx_o), held_gx);
            check_val("stall_gy", int'(gy_o), held_gy);
        end
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        for (int i = 11; i < LW * FH; i++) send(pix(1, i / LW, i % LW));
        send_frame(1);
        idle(3);
        check_frame("b2b", 8, 80, 0);

        // Reset after 7 stale pixels, then a constant frame.
        for (int i = 0; i < 7; i++) send(pix(4, i / LW, i % LW));
        rst = 1'b1;
        #1;
        check_val("rst7_valid", int'(valid_o), 0);
        check_val("rst7_ready", int'(ready_o), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
        send_frame(0);
        idle(3);
        check_frame("rst7", 4, 0, 0);

        // Reset while an output is pending discards it.
        for (int i = 0; i < 11; i++) send(pix(1, i / LW, i % LW));
        check_val("rst11_pre_valid", int'(valid_o), 1);
        check_val("rst11_pre_gx", int'(gx_o), 80);
        rst = 1'b1;
        #1;
        check_val("rst11_valid", int'(valid_o), 0);
        check_val("rst11_gx", int'(gx_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
        send_frame(0);
        idle(3);
        check_frame("rst11", 4, 0, 0);
`else
        // Border mode: one output per pixel, only full windows non-zero.
        clear_q();
        send_frame(1);
        idle(3);
        check_val("border_count", gx_q.size(), LW * FH);
        for (int i = 0; i < gx_q.size(); i++) begin
            check_val($sformatf("border_gx%0d", i), gx_q[i],
                      ((i / LW) >= 2 && (i % LW) >= 2) ? 80 : 0);
            check_val($sformatf("border_gy%0d", i), gy_q[i], 0);
        end
        check_val("border_valid_after", int'(valid_o), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
